// File: rtl/vsync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vsync_gen
//  Purpose  : Vertical timing generator for the VGA driver. Counts clk cycles
//             per scanline and scanlines per frame. Drives VGA_VSYNC, the
//             scaled row index VPIXEL, v_display, and a frame_start pulse.
//             The line-cycle counter restarts on the same reset as the
//             horizontal stage, so line cycle 0 lines up with horizontal
//             count 0.
//  Ports    : clk          in   1  system clock
//             reset        in   1  asynchronous, active-high reset
//             VPIXEL       out  7  row index 0..DISP_LINES/VSCALE-1; 0 outside
//                                  the visible lines
//             VGA_VSYNC    out  1  vertical sync, active low
//             v_display    out  1  high during the visible lines
//             frame_start  out  1  one-cycle pulse on the first cycle of every
//                                  frame except the first one after reset
//  Revision : 1.0  initial release
// ============================================================================
module vsync_gen #(
  parameter int LINE_CYCLES = 1600,
  parameter int PULSE_LINES = 2,
  parameter int BP_LINES    = 29,
  parameter int DISP_LINES  = 480,
  parameter int FP_LINES    = 10,
  parameter int VSCALE      = 5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [6:0] VPIXEL,
  output logic       VGA_VSYNC,
  output logic       v_display,
  output logic       frame_start
);

  localparam int c_CYC_W = (LINE_CYCLES > 1) ? $clog2(LINE_CYCLES) : 1;

  localparam int c_MAX_A     = (PULSE_LINES > BP_LINES) ? PULSE_LINES : BP_LINES;
  localparam int c_MAX_B     = (DISP_LINES > FP_LINES) ? DISP_LINES : FP_LINES;
  localparam int c_MAX_LINES = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int c_LIS_W     = (c_MAX_LINES > 1) ? $clog2(c_MAX_LINES) : 1;

  localparam int c_SUB_W = (VSCALE > 1) ? $clog2(VSCALE) : 1;

  localparam logic [c_CYC_W-1:0] c_LAST_CYC   = c_CYC_W'(LINE_CYCLES - 1);
  localparam logic [c_LIS_W-1:0] c_LAST_SYNC  = c_LIS_W'(PULSE_LINES - 1);
  localparam logic [c_LIS_W-1:0] c_LAST_BP    = c_LIS_W'(BP_LINES - 1);
  localparam logic [c_LIS_W-1:0] c_LAST_DISP  = c_LIS_W'(DISP_LINES - 1);
  localparam logic [c_LIS_W-1:0] c_LAST_FP    = c_LIS_W'(FP_LINES - 1);
  localparam logic [c_SUB_W-1:0] c_LAST_SUB   = c_SUB_W'(VSCALE - 1);
  localparam logic [6:0]         c_LAST_ROW   = 7'(DISP_LINES / VSCALE - 1);

  typedef enum logic [1:0] {
    V_SYNC = 2'd0,
    V_BP   = 2'd1,
    V_DISP = 2'd2,
    V_FP   = 2'd3
  } vstate_t;

  // Registered state
  logic [c_CYC_W-1:0] r_line_cyc;
  vstate_t            r_state;
  logic [c_LIS_W-1:0] r_lis;
  logic [c_SUB_W-1:0] r_sub;
  logic [6:0]         r_vpix;
  logic               r_vsync;
  logic               r_disp;
  logic               r_fs;

  // Next-state values
  logic               w_line_end;
  logic               w_last_line;
  vstate_t            w_state_nxt;
  logic [c_LIS_W-1:0] w_lis_nxt;
  logic [c_SUB_W-1:0] w_sub_nxt;
  logic [6:0]         w_vpix_nxt;
  logic               w_fs_nxt;

  // --------------------------------------------------------------------------
  // State register
  // Outputs are registered from the next-state values so they change on the
  // same edge as the state and are visible from line cycle 0 of the new line.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_line_cyc <= '0;
      r_state    <= V_SYNC;
      r_lis      <= '0;
      r_sub      <= '0;
      r_vpix     <= '0;
      r_vsync    <= 1'b0;
      r_disp     <= 1'b0;
      r_fs       <= 1'b0;
    end else begin
      r_line_cyc <= w_line_end ? '0 : r_line_cyc + 1'b1;
      r_state    <= w_state_nxt;
      r_lis      <= w_lis_nxt;
      r_sub      <= w_sub_nxt;
      r_vpix     <= w_vpix_nxt;
      r_vsync    <= (w_state_nxt != V_SYNC);
      r_disp     <= (w_state_nxt == V_DISP);
      r_fs       <= w_fs_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: only the last cycle of a line advances vertical state.
  // --------------------------------------------------------------------------
  always_comb begin
    w_line_end  = (r_line_cyc == c_LAST_CYC);
    w_last_line = 1'b0;
    w_state_nxt = r_state;
    w_lis_nxt   = r_lis;
    w_sub_nxt   = r_sub;
    w_vpix_nxt  = r_vpix;
    w_fs_nxt    = 1'b0;

    case (r_state)
      V_SYNC:  w_last_line = (r_lis == c_LAST_SYNC);
      V_BP:    w_last_line = (r_lis == c_LAST_BP);
      V_DISP:  w_last_line = (r_lis == c_LAST_DISP);
      V_FP:    w_last_line = (r_lis == c_LAST_FP);
      default: w_last_line = 1'b1;
    endcase

    if (w_line_end) begin
      if (w_last_line) begin
        w_lis_nxt = '0;
        case (r_state)
          V_SYNC: w_state_nxt = V_BP;
          V_BP: begin
            w_state_nxt = V_DISP;
            w_sub_nxt   = '0;
            w_vpix_nxt  = '0;
          end
          // Leaving display takes priority over the row increment that the
          // last visible line would otherwise produce.
          V_DISP: begin
            w_state_nxt = V_FP;
            w_sub_nxt   = '0;
            w_vpix_nxt  = '0;
          end
          V_FP: begin
            w_state_nxt = V_SYNC;
            w_fs_nxt    = 1'b1;
          end
          default: w_state_nxt = V_SYNC;
        endcase
      end else begin
        w_lis_nxt = r_lis + 1'b1;
        if (r_state == V_DISP) begin
          if (r_sub == c_LAST_SUB) begin
            w_sub_nxt = '0;
            // Saturate as a guard for parameter sets where DISP_LINES is not
            // an exact multiple of VSCALE.
            if (r_vpix != c_LAST_ROW) begin
              w_vpix_nxt = r_vpix + 7'd1;
            end
          end else begin
            w_sub_nxt = r_sub + 1'b1;
          end
        end
      end
    end
  end

  assign VPIXEL      = r_vpix;
  assign VGA_VSYNC   = r_vsync;
  assign v_display   = r_disp;
  assign frame_start = r_fs;

endmodule
`default_nettype wire

// File: tb/tb_vsync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vsync_gen
//  Purpose  : Directed self-checking bench for vsync_gen. The line length is
//             shortened to 16 cycles so a full frame is 521*16 = 8336 cycles;
//             every reference cycle number is the full-size one divided by 100.
//             Cycle k is the k-th clock period after reset release; cycle 0
//             is the period in which reset is released.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vsync_gen;

  localparam int L     = 16;
  localparam int FRAME = 521 * L;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] VPIXEL;
  logic       VGA_VSYNC;
  logic       v_display;
  logic       frame_start;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  vsync_gen #(
    .LINE_CYCLES (L),
    .PULSE_LINES (2),
    .BP_LINES    (29),
    .DISP_LINES  (480),
    .FP_LINES    (10),
    .VSCALE      (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .VPIXEL      (VPIXEL),
    .VGA_VSYNC   (VGA_VSYNC),
    .v_display   (v_display),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hold reset for a few edges, release on a falling edge; sample point is
  // then inside cycle 0.
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    cyc = 0;
  endtask

  // Advance to cycle k and sample 1 ns after the rising edge.
  task automatic go(input int k);
    repeat (k - cyc) @(posedge clk);
    #1;
    cyc = k;
  endtask

  initial begin
    int lowcnt [3];
    int hist   [96];
    int bad, offb, over, fscnt, nhist, line, f;
    logic       e_vs, e_disp, e_fs;
    logic [6:0] e_vp, prev;

    // ---- reset state and sync pulse width ----
    do_reset();
    chk("rst_vsync", VGA_VSYNC, 0);
    chk("rst_vpix", VPIXEL, 0);
    chk("rst_disp", v_display, 0);
    chk("rst_fs", frame_start, 0);
    go(31);   chk("vsync_c3199", VGA_VSYNC, 0);
    go(32);   chk("vsync_c3200", VGA_VSYNC, 1);

    // ---- display start and first row step ----
    go(495);  chk("disp_c49599", v_display, 0);
    go(496);  chk("disp_c49600", v_display, 1);
              chk("vpix_c49600", VPIXEL, 0);
    go(575);  chk("vpix_c57599", VPIXEL, 0);
    go(576);  chk("vpix_c57600", VPIXEL, 1);

    // ---- last row and display end ----
    go(8096); chk("vpix_c809600", VPIXEL, 95);
              chk("disp_c809600", v_display, 1);
    go(8175); chk("vpix_c817599", VPIXEL, 95);
    go(8176); chk("vpix_c817600", VPIXEL, 0);
              chk("disp_c817600", v_display, 0);

    // ---- frame wrap ----
    go(8335); chk("vsync_c833599", VGA_VSYNC, 1);
              chk("fs_c833599", frame_start, 0);
    go(8336); chk("vsync_c833600", VGA_VSYNC, 0);
              chk("fs_c833600", frame_start, 1);
    go(8337); chk("fs_c833601", frame_start, 0);
    go(16671); chk("fs_c1667199", frame_start, 0);
    go(16672); chk("fs_c1667200", frame_start, 1);
    go(16673); chk("fs_c1667201", frame_start, 0);

    // ---- asynchronous reset in the middle of display ----
    do_reset();
    go(600);  chk("mid_vpix_before", VPIXEL, 1);
              chk("mid_disp_before", v_display, 1);
    reset = 1'b1;
    #1;       // no clock edge between here and the checks
    chk("mid_rst_vsync", VGA_VSYNC, 0);
    chk("mid_rst_vpix", VPIXEL, 0);
    chk("mid_rst_disp", v_display, 0);
    chk("mid_rst_fs", frame_start, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    cyc = 0;
    go(495);  chk("mid_disp_c49599", v_display, 0);
    go(496);  chk("mid_disp_c49600", v_display, 1);

    // ---- three-frame checker against an arithmetic model ----
    do_reset();
    foreach (lowcnt[i]) lowcnt[i] = 0;
    foreach (hist[i])   hist[i] = 0;
    bad = 0; offb = 0; over = 0; fscnt = 0;
    prev = VPIXEL;
    for (int c = 0; c < 3 * FRAME; c++) begin
      if (c > 0) go(c);
      line   = (c / L) % 521;
      f      = c / FRAME;
      e_vs   = (line >= 2);
      e_disp = (line >= 31) && (line <= 510);
      e_vp   = e_disp ? 7'((line - 31) / 5) : 7'd0;
      e_fs   = (c % FRAME == 0) && (c >= FRAME);
      if (VGA_VSYNC !== e_vs || v_display !== e_disp ||
          VPIXEL !== e_vp || frame_start !== e_fs) bad++;
      if (VGA_VSYNC === 1'b0) lowcnt[f]++;
      if (c > 0 && VPIXEL !== prev && (c % L) != 0) offb++;
      prev = VPIXEL;
      if ((c % L) == 0 && v_display === 1'b1) begin
        if (VPIXEL > 7'd95) over++;
        else hist[VPIXEL]++;
      end
      if (frame_start === 1'b1) fscnt++;
    end
    nhist = 0;
    foreach (hist[i]) if (hist[i] != 15) nhist++;
    chk("model_cycles_bad", bad, 0);
    chk("vsync_low_f0", lowcnt[0], 2 * L);
    chk("vsync_low_f1", lowcnt[1], 2 * L);
    chk("vsync_low_f2", lowcnt[2], 2 * L);
    chk("vpix_change_off_boundary", offb, 0);
    chk("vpix_over_95", over, 0);
    chk("rows_not_5_lines", nhist, 0);
    chk("fs_pulse_count", fscnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
